sm_step_ctrl: RTL
=================

SM_STEP_CTRL -- requirements
Module: sm_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 50000, meaning consecutive clkIn cycles a stepBtn change must persist before it is accepted (legal range 1..2^20).
REQ-002 SHALL have port clkIn, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port runSw, input, 1, raw asynchronous free-run switch.
REQ-005 SHALL have port stepBtn, input, 1, raw asynchronous bouncing step button.
REQ-006 SHALL have port stepNum, input, 4, CPU cycles per step minus one (1..16 steps).
REQ-007 SHALL have port cpuEn, output, 1, CPU clock enable, high on each cycle the CPU advances.
REQ-008 SHALL have port stepDone, output, 1, one-cycle pulse on step-burst completion.
REQ-009 SHALL have port state, output, 2, current FSM state encoding for LED display.

Function
REQ-010 SHALL pass runSw and stepBtn each through a 2-flop synchronizer (runS, btnS); runSw SHALL NOT be debounced.
REQ-011 SHALL keep a debounced level btnD: counter increments each cycle btnS != btnD, clears to 0 on any cycle btnS == btnD; btnD toggles and counter clears when the mismatch has persisted DEBOUNCE consecutive cycles.
REQ-012 SHALL generate press, a one-cycle pulse on each 0->1 transition of btnD.
REQ-013 SHALL implement FSM states IDLE=2'd0, RUN=2'd1, STEP=2'd2, HOLD=2'd3, driven on output state.
REQ-014 IDLE: if runS=1 go RUN; else if press go STEP and load cnt <= stepNum; runS has priority over a simultaneous press.
REQ-015 RUN: press ignored; go IDLE when runS=0.
REQ-016 STEP: cnt decrements each cycle; when cnt==0 go HOLD; runS, press and stepNum changes ignored until burst ends (burst never truncated except by rst).
REQ-017 HOLD: remain while btnD=1; when btnD=0 go RUN if runS=1, else IDLE.
REQ-018 cpuEn SHALL be combinational from state: 1 in RUN or STEP, 0 otherwise; a burst SHALL give exactly stepNum+1 consecutive cpuEn cycles, stepNum sampled at the press cycle.
REQ-019 stepDone SHALL be registered, high exactly on the first cycle in HOLD, 0 otherwise.
REQ-020 A button still held when rst deasserts SHALL register as a press once stable for DEBOUNCE cycles (btnD restarts at 0).
REQ-021 Debounce counter SHALL be sized to hold DEBOUNCE without wrap; no arithmetic overflow permitted.

Reset
REQ-022 While rst=1 (asynchronous, immediate): state=IDLE, cpuEn=0, stepDone=0, cnt=0, synchronizer flops=0, btnD=0, debounce counter=0.
REQ-023 rst asserted mid-STEP or mid-RUN SHALL abort immediately with cpuEn=0 and no stepDone pulse.

Verification (DEBOUNCE=4)
REQ-024 stepNum=3, stepBtn high 12 cycles then low -> cpuEn high exactly 4 consecutive cycles, stepDone single pulse on first HOLD cycle, state returns to 0 after release debounced.
REQ-025 stepBtn high 2 cycles then low (glitch < DEBOUNCE) -> btnD stays 0, cpuEn never asserts, state stays 0.
REQ-026 runSw 0->1 -> cpuEn high on 3rd rising edge after change and stays high; runSw 1->0 -> cpuEn low on 3rd edge; presses during RUN change nothing.
REQ-027 stepNum=15, press, runSw raised during burst, button held -> exactly 16 cpuEn cycles, then HOLD (cpuEn 0) until btnD=0, then RUN (cpuEn 1).
REQ-028 stepNum=7, press, rst pulsed after 3 cpuEn cycles -> cpuEn 0 in same cycle as rst, state 0, stepDone never pulses; stepNum changed to 2 mid-burst in separate run -> still 8 cpuEn cycles.

Source files
------------

// File: rtl/sm_step_ctrl.sv
// sm_step_ctrl: single-step / free-run controller for a CPU clock enable.
// Synchronizes the run switch and step button, debounces the button, and
// runs a small FSM that either lets the CPU free-run or issues a burst of
// stepNum+1 enable cycles per debounced button press.
module sm_step_ctrl #(
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic       clkIn,
    input  logic       rst,
    input  logic       runSw,
    input  logic       stepBtn,
    input  logic [3:0] stepNum,
    output logic       cpuEn,
    output logic       stepDone,
    output logic [1:0] state
);

    // Counter wide enough to represent DEBOUNCE itself, so it can never wrap.
    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    logic            r_run_meta;
    logic            r_run_sync;
    logic            r_btn_meta;
    logic            r_btn_sync;
    logic            r_btn_deb;
    logic            r_btn_deb_d;
    logic [DB_W-1:0] r_db_cnt;
    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_step_done;

    state_t          w_state_nxt;
    logic [3:0]      w_cnt_nxt;
    logic            w_done_nxt;
    logic            w_press;

    // Two-flop synchronizers for both raw asynchronous inputs.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            r_run_meta <= 1'b0;
            r_run_sync <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_run_meta <= runSw;
            r_run_sync <= r_run_meta;
            r_btn_meta <= stepBtn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debouncer: accept a button change only after DEBOUNCE consecutive mismatch cycles.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            r_btn_deb <= 1'b0;
            r_db_cnt  <= {DB_W{1'b0}};
        end else if (r_btn_sync != r_btn_deb) begin
            if (r_db_cnt == DB_LAST) begin
                r_btn_deb <= ~r_btn_deb;
                r_db_cnt  <= {DB_W{1'b0}};
            end else begin
                r_btn_deb <= r_btn_deb;
                r_db_cnt  <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_btn_deb <= r_btn_deb;
            r_db_cnt  <= {DB_W{1'b0}};
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            r_btn_deb_d <= 1'b0;
        end else begin
            r_btn_deb_d <= r_btn_deb;
        end
    end

    assign w_press = r_btn_deb & ~r_btn_deb_d;

    // FSM state, burst counter and completion-pulse registers.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step_done <= w_done_nxt;
        end
    end

    // Next-state logic; a running burst ignores everything until it completes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (r_run_sync) begin
                    w_state_nxt = ST_RUN;
                end else if (w_press) begin
                    w_state_nxt = ST_STEP;
                    w_cnt_nxt   = stepNum;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!r_run_sync) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_btn_deb) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_run_sync) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_done_nxt = (w_state_nxt == ST_HOLD) && (r_state != ST_HOLD);
    end

    assign cpuEn    = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign stepDone = r_step_done;
    assign state    = r_state;

endmodule
